// File: rtl/uart_rx_deserializer_if.sv
// Bundle of serial-line, frame-config and received-data signals for the UART receive path.
// data_valid/par_err/stp_err are one-cycle strobes with no ready: the consumer must take P_DATA in the strobe cycle.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    // Receiver FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
    logic [2:0]            state_dbg;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, state_dbg
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, state_dbg
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes RX_IN, majority-votes each bit at mid-bit, shifts data LSB-first,
// checks optional parity and the stop bit, and reports the outcome as one-cycle pulses.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8   // 8, 16 or 32 only
) (
    input logic                   CLK,
    input logic                   RST,
    uart_rx_deserializer_if.slave bus
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] TICK_ONE  = CW'(1);
    localparam logic [CW-1:0] TICK_S0   = CW'(H - 1);
    localparam logic [CW-1:0] TICK_S1   = CW'(H);
    localparam logic [CW-1:0] TICK_S2   = CW'(H + 1);
    localparam logic [CW-1:0] TICK_STOP = CW'(H + 2);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [CW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  brk_q, brk_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic voted;
    logic exp_par;
    logic tick_last;

    assign voted     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign exp_par   = par_typ_q ? ~^shift_q : ^shift_q;
    assign tick_last = (edge_cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.RX_IN;
        rx_s_d       = sync1_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        brk_d        = brk_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = tick_last ? '0 : edge_cnt_q + 1'b1;
            if (edge_cnt_q == TICK_S0) samp_d[0] = rx_s_q;
            if (edge_cnt_q == TICK_S1) samp_d[1] = rx_s_q;
            if (edge_cnt_q == TICK_S2) samp_d[2] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                // After a break the line must be seen high before a new start is accepted.
                if (brk_q) begin
                    if (rx_s_q) brk_d = 1'b0;
                end else if (!rx_s_q) begin
                    state_d    = S_START;
                    edge_cnt_d = TICK_ONE;
                end
            end
            S_START: begin
                if (tick_last) begin
                    if (voted) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        par_en_d  = bus.PAR_EN;
                        par_typ_d = bus.PAR_TYP;
                        par_bad_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    shift_d   = {voted, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick_last) begin
                    par_bad_d = (voted != exp_par);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                // Decide early in the stop bit so a following start edge is not missed.
                if (edge_cnt_q == TICK_STOP) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    if (!voted) begin
                        stp_err_d = 1'b1;
                        brk_d     = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            brk_q        <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            brk_q        <= brk_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are built from their bit lists, the expected
// outcome and its arrival cycle are queued, and a negedge monitor compares every cycle.
module tb_uart_rx_deserializer;
    localparam int DW = 8;
    localparam int OS = 8;
    localparam int H  = OS / 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus();

    uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Entry: {pulse cycle[31:0], {dv, pe, se}[2:0], data[7:0]}
    logic [42:0] exp_q[$];
    logic [42:0] cmp_e;
    logic [2:0]  cmp_got;
    logic [7:0]  model_pdata = 8'h00;
    logic        chk_en = 1'b0;
    int          start_cyc = 0;
    int          dv_cyc = -1;
    int          pe_cyc = -1;
    int          se_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return odd ? logic'((ones + 1) % 2) : logic'(ones % 2);
    endfunction

    task automatic step(input logic v);
        bus.RX_IN = v;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    // glitch_bit: frame bit index whose tick H is inverted; cut_cycles >= 0 stops the frame early.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic par_bit, input logic stop_bit,
                              input int glitch_bit, input int cut_cycles);
        logic        bits[$];
        logic [2:0]  pulses;
        logic [31:0] t;
        int          n;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        bus.PAR_EN  = pe;
        bus.PAR_TYP = pt;
        start_cyc   = cyc;
        if (cut_cycles < 0) begin
            if (!stop_bit)                             pulses = 3'b001;
            else if (pe && (par_bit != exp_par(d, pt))) pulses = 3'b010;
            else                                       pulses = 3'b100;
            // 2 sync cycles, then start+data+parity bits, then stop-bit decision at tick H+2.
            t = 32'(start_cyc + 2 + (bits.size() - 1) * OS + H + 3);
            exp_q.push_back({t, pulses, d});
        end
        n = 0;
        foreach (bits[j]) begin
            for (int k = 0; k < OS; k++) begin
                if (cut_cycles >= 0 && n >= cut_cycles) return;
                step((j == glitch_bit && k == H) ? ~bits[j] : bits[j]);
                n++;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST && chk_en) begin
            cmp_got = {bus.data_valid, bus.par_err, bus.stp_err};
            if (cmp_got[2]) dv_cyc = cyc;
            if (cmp_got[1]) pe_cyc = cyc;
            if (cmp_got[0]) se_cyc = cyc;
            if (exp_q.size() > 0 && exp_q[0][42:11] == 32'(cyc)) begin
                cmp_e = exp_q.pop_front();
                check("pulse", 64'(cmp_got), 64'(cmp_e[10:8]));
                if (cmp_e[10]) model_pdata = cmp_e[7:0];
            end else begin
                check("no_pulse", 64'(cmp_got), 64'd0);
            end
            check("p_data", 64'(bus.P_DATA), 64'(model_pdata));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        RST         = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_p_data", 64'(bus.P_DATA), 64'h00);
        check("reset_pulses", 64'({bus.data_valid, bus.par_err, bus.stp_err}), 64'd0);
        check("reset_state", 64'(bus.state_dbg), 64'd0);
        RST    = 1'b1;
        chk_en = 1'b1;
        idle(5);

        check("model_par_even_3c", 64'(exp_par(8'h3C, 1'b0)), 64'd0);
        check("model_par_odd_3c", 64'(exp_par(8'h3C, 1'b1)), 64'd1);
        check("model_par_even_01", 64'(exp_par(8'h01, 1'b0)), 64'd1);

        // No parity, 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("t1_latency", 64'(dv_cyc - start_cyc), 64'd81);
        check("t1_p_data", 64'(bus.P_DATA), 64'hA5);

        // Even parity, good then bad
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("t2_latency", 64'(dv_cyc - start_cyc), 64'd89);
        check("t2_p_data", 64'(bus.P_DATA), 64'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(6);
        check("t2_par_err_latency", 64'(pe_cyc - start_cyc), 64'd89);
        check("t2_p_data_hold", 64'(bus.P_DATA), 64'h3C);

        // Odd parity: 0x07 has three ones, parity bit 0
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("t2_odd_p_data", 64'(bus.P_DATA), 64'h07);

        // Stop bit 0
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(10);
        check("t3_stp_latency", 64'(se_cyc - start_cyc), 64'd81);
        check("t3_p_data_hold", 64'(bus.P_DATA), 64'h07);

        // Short idle glitch, then mid-bit glitches on data bits
        step(1'b0);
        step(1'b0);
        idle(20);
        check("t4_state_idle", 64'(bus.state_dbg), 64'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
        idle(6);
        check("t4_glitch_bit2", 64'(bus.P_DATA), 64'hF0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1);
        idle(6);
        check("t4_glitch_bit7", 64'(bus.P_DATA), 64'h0F);

        // Back-to-back frames
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("t5_second_latency", 64'(dv_cyc - start_cyc), 64'd81);
        check("t5_p_data", 64'(bus.P_DATA), 64'hFE);

        // Break: line stays low well past the frame
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        repeat (40) step(1'b0);
        check("brk_state_idle", 64'(bus.state_dbg), 64'd0);
        idle(10);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("brk_rearm_p_data", 64'(bus.P_DATA), 64'h5A);

        // Reset during data bit 4
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * OS + 4);
        RST = 1'b0;
        #1;
        check("t6_reset_p_data", 64'(bus.P_DATA), 64'h00);
        check("t6_reset_pulses", 64'({bus.data_valid, bus.par_err, bus.stp_err}), 64'd0);
        check("t6_reset_state", 64'(bus.state_dbg), 64'd0);
        exp_q.delete();
        model_pdata = 8'h00;
        bus.RX_IN   = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(5);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(6);
        check("t6_latency", 64'(dv_cyc - start_cyc), 64'd81);
        check("t6_p_data", 64'(bus.P_DATA), 64'h7E);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
